// File: rtl/sdram_avm_arbiter.sv
// Two-client Avalon-MM arbiter with a read-tag FIFO that routes readdatavalid beats back to the issuer.
// Define ARB_FIXED_PRIO_EN for fixed client-0 priority; otherwise clients alternate round-robin.
module sdram_avm_arbiter #(
  parameter int unsigned ADDR_W          = 25,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_c0_req,
  input  logic                i_c1_req,
  input  logic                i_c0_we,
  input  logic                i_c1_we,
  input  logic [ADDR_W-1:0]   i_c0_addr,
  input  logic [ADDR_W-1:0]   i_c1_addr,
  input  logic [DATA_W-1:0]   i_c0_wdata,
  input  logic [DATA_W-1:0]   i_c1_wdata,
  input  logic [DATA_W/8-1:0] i_c0_be,
  input  logic [DATA_W/8-1:0] i_c1_be,
  output logic                o_c0_gnt,
  output logic                o_c1_gnt,
  output logic [DATA_W-1:0]   o_c0_rdata,
  output logic [DATA_W-1:0]   o_c1_rdata,
  output logic                o_c0_rvalid,
  output logic                o_c1_rvalid,
  output logic [ADDR_W-1:0]   o_avm_address,
  output logic [DATA_W/8-1:0] o_avm_byteenable,
  output logic                o_avm_chipselect,
  output logic [DATA_W-1:0]   o_avm_writedata,
  output logic                o_avm_read,
  output logic                o_avm_write,
  input  logic [DATA_W-1:0]   i_avm_readdata,
  input  logic                i_avm_readdatavalid,
  input  logic                i_avm_waitrequest
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic { S_IDLE = 1'b0, S_ISSUE = 1'b1 } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

  state_e state_q, state_d;
  cmd_t   c0_cmd, c1_cmd, sel_cmd;
  logic   c0_elig, c1_elig, sel_c1, any_elig;
  logic   accept, push, pop, fifo_full, fifo_empty, head_tag;

  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rd_q, rd_d, wr_q, wr_d, cs_q, cs_d;

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]           wptr_q, rptr_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       rv0_q, rv1_q;
  logic [DATA_W-1:0]          rdat0_q, rdat1_q;

  assign c0_cmd     = {i_c0_we, i_c0_addr, i_c0_wdata, i_c0_be};
  assign c1_cmd     = {i_c1_we, i_c1_addr, i_c1_wdata, i_c1_be};
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head_tag   = tag_q[rptr_q];

  // A read is only eligible while a tag slot is free to track it.
  assign c0_elig  = i_c0_req & (i_c0_we | ~fifo_full);
  assign c1_elig  = i_c1_req & (i_c1_we | ~fifo_full);
  assign any_elig = c0_elig | c1_elig;
  assign sel_cmd  = sel_c1 ? c1_cmd : c0_cmd;

`ifdef ARB_FIXED_PRIO_EN
  assign sel_c1 = c1_elig & ~c0_elig;
`else
  logic rr_q;  // last granted client; the other one wins a tie

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    rr_q <= 1'b0;
    else if (accept) rr_q <= owner_q;
  end

  assign sel_c1 = c1_elig & (~c0_elig | ~rr_q);
`endif

  assign accept   = (state_q == S_ISSUE) & ~i_avm_waitrequest;
  assign push     = accept & rd_q;
  assign pop      = i_avm_readdatavalid & ~fifo_empty;
  assign o_c0_gnt = accept & ~owner_q;
  assign o_c1_gnt = accept & owner_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_elig) state_d = S_ISSUE;
      S_ISSUE: if (!i_avm_waitrequest) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered Avalon command; held stable while stalled.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cs_d    = cs_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          owner_d = sel_c1;
          addr_d  = sel_cmd.addr;
          wdata_d = sel_cmd.wdata;
          be_d    = sel_cmd.be;
          rd_d    = ~sel_cmd.we;
          wr_d    = sel_cmd.we;
          cs_d    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!i_avm_waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          cs_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
    end
  end

  // Read-tag FIFO: one client bit per outstanding read, in issue order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wptr_q] <= owner_q;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rdat0_q <= '0;
      rdat1_q <= '0;
    end else begin
      rv0_q <= pop & ~head_tag;
      rv1_q <= pop & head_tag;
      if (pop && !head_tag) rdat0_q <= i_avm_readdata;
      if (pop && head_tag)  rdat1_q <= i_avm_readdata;
    end
  end

  assign o_avm_address    = addr_q;
  assign o_avm_byteenable = be_q;
  assign o_avm_writedata  = wdata_q;
  assign o_avm_read       = rd_q;
  assign o_avm_write      = wr_q;
  assign o_avm_chipselect = cs_q;
  assign o_c0_rvalid      = rv0_q;
  assign o_c1_rvalid      = rv1_q;
  assign o_c0_rdata       = rdat0_q;
  assign o_c1_rdata       = rdat1_q;

endmodule

// File: tb/tb_sdram_avm_arbiter.sv
// Directed self-checking bench for sdram_avm_arbiter; honours ARB_FIXED_PRIO_EN for tie expectations.
module tb_sdram_avm_arbiter;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_c0_req, i_c1_req, i_c0_we, i_c1_we;
  logic [ADDR_W-1:0] i_c0_addr, i_c1_addr;
  logic [DATA_W-1:0] i_c0_wdata, i_c1_wdata;
  logic [BE_W-1:0]   i_c0_be, i_c1_be;
  logic              o_c0_gnt, o_c1_gnt, o_c0_rvalid, o_c1_rvalid;
  logic [DATA_W-1:0] o_c0_rdata, o_c1_rdata;
  logic [ADDR_W-1:0] o_avm_address;
  logic [BE_W-1:0]   o_avm_byteenable;
  logic              o_avm_chipselect, o_avm_read, o_avm_write;
  logic [DATA_W-1:0] o_avm_writedata;
  logic [DATA_W-1:0] i_avm_readdata;
  logic              i_avm_readdatavalid, i_avm_waitrequest;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  sdram_avm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_c0_req(i_c0_req), .i_c1_req(i_c1_req), .i_c0_we(i_c0_we), .i_c1_we(i_c1_we),
    .i_c0_addr(i_c0_addr), .i_c1_addr(i_c1_addr), .i_c0_wdata(i_c0_wdata), .i_c1_wdata(i_c1_wdata),
    .i_c0_be(i_c0_be), .i_c1_be(i_c1_be), .o_c0_gnt(o_c0_gnt), .o_c1_gnt(o_c1_gnt),
    .o_c0_rdata(o_c0_rdata), .o_c1_rdata(o_c1_rdata), .o_c0_rvalid(o_c0_rvalid), .o_c1_rvalid(o_c1_rvalid),
    .o_avm_address(o_avm_address), .o_avm_byteenable(o_avm_byteenable), .o_avm_chipselect(o_avm_chipselect),
    .o_avm_writedata(o_avm_writedata), .o_avm_read(o_avm_read), .o_avm_write(o_avm_write),
    .i_avm_readdata(i_avm_readdata), .i_avm_readdatavalid(i_avm_readdatavalid),
    .i_avm_waitrequest(i_avm_waitrequest)
  );

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_c0_req = 0; i_c1_req = 0; i_c0_we = 0; i_c1_we = 0;
    i_c0_addr = '0; i_c1_addr = '0; i_c0_wdata = '0; i_c1_wdata = '0;
    i_c0_be = '0; i_c1_be = '0;
    i_avm_readdata = '0; i_avm_readdatavalid = 0; i_avm_waitrequest = 0;
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    cyc(); cyc();
    i_rst_n = 1;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    idle_inputs();
    i_rst_n = 0;
    cyc(); cyc();
    outs = {o_c0_gnt, o_c1_gnt, o_c0_rvalid, o_c1_rvalid, o_avm_chipselect, o_avm_read, o_avm_write, 1'b0};
    checks++;
    if (outs !== 8'h00) begin $display("FAIL reset_strobes got=%h exp=00", outs); failures++; end
    checks++;
    if ({o_avm_address, o_avm_writedata, o_avm_byteenable, o_c0_rdata, o_c1_rdata} !== '0) begin
      $display("FAIL reset_data addr=%h wdata=%h be=%h", o_avm_address, o_avm_writedata, o_avm_byteenable);
      failures++;
    end
    i_rst_n = 1;
    cyc();
  endtask

  task automatic test_write();
    i_c0_req = 1; i_c0_we = 1; i_c0_addr = 25'h10; i_c0_wdata = 32'hDEADBEEF; i_c0_be = 4'hF;
    cyc();
    checks++;
    if ({o_avm_write, o_avm_read, o_avm_chipselect} !== 3'b101) begin
      $display("FAIL wr_strobes got=%b exp=101", {o_avm_write, o_avm_read, o_avm_chipselect}); failures++;
    end
    checks++;
    if (o_avm_address !== 25'h10 || o_avm_writedata !== 32'hDEADBEEF || o_avm_byteenable !== 4'hF) begin
      $display("FAIL wr_fields addr=%h wdata=%h be=%h", o_avm_address, o_avm_writedata, o_avm_byteenable);
      failures++;
    end
    checks++;
    if ({o_c0_gnt, o_c1_gnt} !== 2'b10) begin $display("FAIL wr_gnt got=%b exp=10", {o_c0_gnt, o_c1_gnt}); failures++; end
    i_c0_req = 0;
    cyc();
    checks++;
    if ({o_avm_write, o_avm_chipselect, o_c0_gnt} !== 3'b000) begin
      $display("FAIL wr_one_cycle got=%b exp=000", {o_avm_write, o_avm_chipselect, o_c0_gnt}); failures++;
    end
  endtask

  task automatic test_wait_read();
    i_c1_req = 1; i_c1_we = 0; i_c1_addr = 25'h20;
    for (int i = 0; i < 4; i++) begin
      cyc();
      i_avm_waitrequest = (i < 3);
      #1;
      checks++;
      if ({o_avm_read, o_avm_chipselect, o_avm_write} !== 3'b110 || o_avm_address !== 25'h20) begin
        $display("FAIL rd_stable cyc=%0d rd/cs/wr=%b addr=%h", i, {o_avm_read, o_avm_chipselect, o_avm_write}, o_avm_address);
        failures++;
      end
      checks++;
      if (o_c1_gnt !== (i == 3) || o_c0_gnt !== 1'b0) begin
        $display("FAIL rd_gnt cyc=%0d got=%b%b exp c1=%0d", i, o_c0_gnt, o_c1_gnt, i == 3); failures++;
      end
    end
    i_c1_req = 0;
    cyc();
    checks++;
    if (o_avm_read !== 1'b0) begin $display("FAIL rd_drop got=%b exp=0", o_avm_read); failures++; end
    i_avm_readdatavalid = 1; i_avm_readdata = 32'h12345678;
    cyc();
    i_avm_readdatavalid = 0;
    checks++;
    if ({o_c0_rvalid, o_c1_rvalid} !== 2'b01 || o_c1_rdata !== 32'h12345678) begin
      $display("FAIL rd_return rv=%b%b rdata=%h exp rv=01 rdata=12345678", o_c0_rvalid, o_c1_rvalid, o_c1_rdata);
      failures++;
    end
    cyc();
    checks++;
    if (o_c1_rvalid !== 1'b0 || o_c1_rdata !== 32'h12345678) begin
      $display("FAIL rd_pulse rv=%b rdata=%h", o_c1_rvalid, o_c1_rdata); failures++;
    end
  endtask

  task automatic test_alternate();
    logic order [4];
    logic got;
    logic exp_c1;
    do_reset();
    i_c0_req = 1; i_c0_we = 0; i_c0_addr = 25'h100;
    i_c1_req = 1; i_c1_we = 0; i_c1_addr = 25'h200;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int t = 0; t < 4 && !got; t++) begin
        cyc();
        if (o_c0_gnt || o_c1_gnt) got = 1;
      end
`ifdef ARB_FIXED_PRIO_EN
      exp_c1 = 1'b0;
`else
      exp_c1 = (g % 2 == 0);
`endif
      checks++;
      if (!got) begin
        $display("FAIL alt_timeout grant=%0d", g); failures++;
      end else if (o_c1_gnt !== exp_c1 || o_avm_address !== (exp_c1 ? 25'h200 : 25'h100)) begin
        $display("FAIL alt_order grant=%0d c1_gnt=%b exp=%b addr=%h", g, o_c1_gnt, exp_c1, o_avm_address);
        failures++;
      end
      order[g] = exp_c1;
      if (g == 3) begin i_c0_req = 0; i_c1_req = 0; end
    end
    for (int k = 0; k < 4; k++) begin
      i_avm_readdatavalid = 1; i_avm_readdata = 32'hA0 + k;
      cyc();
      checks++;
      if ({o_c0_rvalid, o_c1_rvalid} !== (order[k] ? 2'b01 : 2'b10) ||
          (order[k] ? o_c1_rdata : o_c0_rdata) !== 32'hA0 + k) begin
        $display("FAIL alt_route beat=%0d rv=%b%b c0=%h c1=%h exp_c1=%b data=%h", k, o_c0_rvalid, o_c1_rvalid,
                 o_c0_rdata, o_c1_rdata, order[k], 32'hA0 + k);
        failures++;
      end
    end
    i_avm_readdatavalid = 0;
    cyc();
  endtask

  task automatic test_full();
    int n;
    logic got;
    i_c0_req = 1; i_c0_we = 0; i_c0_addr = 25'h40;
    n = 0;
    for (int t = 0; t < 12; t++) begin cyc(); if (o_c0_gnt) n++; end
    checks++;
    if (n != 4) begin $display("FAIL full_reads got=%0d exp=4", n); failures++; end
    i_c1_req = 1; i_c1_we = 1; i_c1_addr = 25'h44; i_c1_wdata = 32'h0BADF00D; i_c1_be = 4'h3;
    got = 0;
    for (int t = 0; t < 4 && !got; t++) begin
      cyc();
      if (o_c1_gnt) got = 1;
      if (o_c0_gnt) n++;
    end
    checks++;
    if (!got || o_avm_write !== 1'b1 || o_avm_writedata !== 32'h0BADF00D || n != 4) begin
      $display("FAIL full_write got=%b wr=%b wdata=%h c0_grants=%0d exp 1/1/0badf00d/4", got, o_avm_write, o_avm_writedata, n);
      failures++;
    end
    i_c1_req = 0;
    for (int t = 0; t < 4; t++) begin cyc(); if (o_c0_gnt) n++; end
    checks++;
    if (n != 4) begin $display("FAIL full_blocked c0_grants=%0d exp=4", n); failures++; end
    i_avm_readdatavalid = 1; i_avm_readdata = 32'h55;
    cyc();
    i_avm_readdatavalid = 0;
    checks++;
    if (o_c0_rvalid !== 1'b1 || o_c0_rdata !== 32'h55) begin
      $display("FAIL full_pop rv=%b rdata=%h exp 1/55", o_c0_rvalid, o_c0_rdata); failures++;
    end
    got = 0;
    for (int t = 0; t < 4 && !got; t++) begin cyc(); if (o_c0_gnt) got = 1; end
    checks++;
    if (!got) begin $display("FAIL fifth_read got=0 exp=1"); failures++; end
    i_c0_req = 0;
    for (int k = 0; k < 4; k++) begin
      i_avm_readdatavalid = 1; i_avm_readdata = 32'h60 + k;
      cyc();
      checks++;
      if ({o_c0_rvalid, o_c1_rvalid} !== 2'b10 || o_c0_rdata !== 32'h60 + k) begin
        $display("FAIL full_drain beat=%0d rv=%b%b rdata=%h", k, o_c0_rvalid, o_c1_rvalid, o_c0_rdata); failures++;
      end
    end
    i_avm_readdatavalid = 0;
    cyc();
  endtask

  task automatic test_empty_rdv();
    logic got;
    i_avm_readdatavalid = 1; i_avm_readdata = 32'hBAD;
    cyc();
    i_avm_readdatavalid = 0;
    checks++;
    if ({o_c0_rvalid, o_c1_rvalid} !== 2'b00 || o_c0_rdata !== 32'h63) begin
      $display("FAIL empty_drop rv=%b%b c0_rdata=%h exp 00/63", o_c0_rvalid, o_c1_rvalid, o_c0_rdata); failures++;
    end
    i_c1_req = 1; i_c1_we = 0; i_c1_addr = 25'h30;
    got = 0;
    for (int t = 0; t < 4 && !got; t++) begin cyc(); if (o_c1_gnt) got = 1; end
    i_c1_req = 0;
    checks++;
    if (!got) begin $display("FAIL empty_gnt got=0 exp=1"); failures++; end
    cyc();
    i_avm_readdatavalid = 1; i_avm_readdata = 32'hCAFE0001;
    cyc();
    i_avm_readdatavalid = 0;
    checks++;
    if ({o_c0_rvalid, o_c1_rvalid} !== 2'b01 || o_c1_rdata !== 32'hCAFE0001) begin
      $display("FAIL empty_roundtrip rv=%b%b rdata=%h", o_c0_rvalid, o_c1_rvalid, o_c1_rdata); failures++;
    end
    cyc();
  endtask

  task automatic test_reset_midop();
    int n;
    int rv;
    i_c0_req = 1; i_c0_we = 0; i_c0_addr = 25'h70;
    n = 0;
    for (int t = 0; t < 4; t++) begin cyc(); if (o_c0_gnt) n++; end
    i_avm_waitrequest = 1;
    cyc();
    checks++;
    if (n != 2 || o_avm_read !== 1'b1) begin
      $display("FAIL midop_setup grants=%0d rd=%b exp 2/1", n, o_avm_read); failures++;
    end
    i_rst_n = 0;
    #1;
    checks++;
    if ({o_c0_gnt, o_c1_gnt, o_avm_read, o_avm_write, o_avm_chipselect, o_c0_rvalid, o_c1_rvalid} !== 7'b0 ||
        o_avm_address !== '0) begin
      $display("FAIL midop_async rd=%b cs=%b addr=%h", o_avm_read, o_avm_chipselect, o_avm_address); failures++;
    end
    idle_inputs();
    cyc();
    i_rst_n = 1;
    rv = 0;
    for (int k = 0; k < 3; k++) begin
      i_avm_readdatavalid = (k < 2);
      cyc();
      if (o_c0_rvalid || o_c1_rvalid) rv++;
    end
    checks++;
    if (rv != 0 || o_avm_chipselect !== 1'b0) begin
      $display("FAIL midop_late_rdv rvalids=%0d cs=%b exp 0/0", rv, o_avm_chipselect); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_alternate();
    test_full();
    test_empty_rdv();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
